key_debounce_multi: RTL and testbench

- Parameterised N-channel successor to the single-key debouncer.
- Each channel provides: 2-FF synchroniser, per-channel stability counter, debounced level, press/release strobes and a long-press strobe. Optional auto-repeat while a key is held.
- Sits between board push-buttons and the control/menu logic of the slave; all outputs are registered in the clk domain.

---
 rtl/key_debounce_multi.sv | 199 +++++++++++++++++++
 tb/tb_key_debounce_multi.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N-channel push-button conditioner. Each channel has a
// 2-FF synchroniser, a saturating stability counter, a debounced level,
// press/release strobes and a long-press strobe driven by a per-key hold FSM.
// Optional auto-repeat while held: define KEY_DEBOUNCE_REPEAT_EN.
// All outputs are registered in the clk domain.

module key_debounce_chan #(
  parameter int DB_CYC     = 20,
  parameter int LONG_CYC   = 100,
  parameter int REP_CYC    = 50,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_pressed,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);
  localparam int DBW  = $clog2(DB_CYC) + 1;
  localparam int HMAX = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int HW   = $clog2(HMAX) + 1;
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);
  localparam logic [DBW-1:0] DB_MAX   = DBW'(DB_CYC);
  localparam logic [HW-1:0]  LONG_MAX = HW'(LONG_CYC);
`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam logic [HW-1:0]  REP_MAX  = HW'(REP_CYC);
`endif

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG, S_REPEAT} state_e;

  logic           sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DBW-1:0] cnt_q, cnt_d;
  logic           level_q, level_d, pressed_q, pressed_d, pdly_q, pdly_d;
  logic           press_q, press_d, release_q, release_d;
  state_e         state_q, state_d;
  logic [HW-1:0]  hcnt_q, hcnt_d, hinc;
  logic           long_q, long_d;

  assign hinc = hcnt_q + HW'(1);

  // Synchroniser, stability counter, level acceptance and edge strobes.
  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
    if (sync1_q != sync2_q)  cnt_d = '0;
    else if (cnt_q == DB_MAX) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + DBW'(1);
    level_d = level_q;
    if (cnt_q == DB_MAX && sync2_q != level_q) level_d = sync2_q;
    // pressed tracks the new level in the same cycle it is accepted
    pressed_d = level_d ^ IDLE_LVL;
    pdly_d    = pressed_q;
    press_d   = pressed_q & ~pdly_q;
    release_d = ~pressed_q & pdly_q;
  end

  // Debounce-path registers; reset puts everything at the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= IDLE_LVL;
      sync2_q   <= IDLE_LVL;
      cnt_q     <= '0;
      level_q   <= IDLE_LVL;
      pressed_q <= 1'b0;
      pdly_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pressed_q <= pressed_d;
      pdly_q    <= pdly_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Hold FSM next state; release wins over everything and clears the counter.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    if (release_q) begin
      state_d = S_IDLE;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: if (press_q) begin
          state_d = S_HELD;
          hcnt_d  = '0;
        end
        S_HELD: if (hinc == LONG_MAX) begin
          state_d = S_LONG;
          hcnt_d  = '0;
        end else begin
          hcnt_d  = hinc;
        end
`ifdef KEY_DEBOUNCE_REPEAT_EN
        S_LONG, S_REPEAT: begin
          state_d = S_REPEAT;
          hcnt_d  = (hinc == REP_MAX) ? '0 : hinc;
        end
`else
        S_LONG: ; // parked until release
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Hold FSM outputs; a strobe due in a release cycle is dropped.
  always_comb begin
    long_d = 1'b0;
    if (!release_q && state_q == S_HELD) long_d = (hinc == LONG_MAX);
  end

  // Hold FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      long_q  <= long_d;
    end
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  logic repeat_q, repeat_d;

  // Repeat strobe every REP_CYC cycles once the long press has fired.
  always_comb begin
    repeat_d = 1'b0;
    if (!release_q && (state_q == S_LONG || state_q == S_REPEAT))
      repeat_d = (hinc == REP_MAX);
  end

  // Repeat strobe register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) repeat_q <= 1'b0;
    else     repeat_q <= repeat_d;
  end

  assign key_repeat = repeat_q;
`else
  assign key_repeat = 1'b0;
`endif

  assign key_level   = level_q;
  assign key_pressed = pressed_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
endmodule

module key_debounce_multi #(
  parameter int NUM_KEYS     = 4,
  parameter int CLK_FREQ_KHZ = 100000,
  parameter int DEBOUNCE_MS  = 20,
  parameter int LONG_MS      = 1000,
  parameter int REPEAT_MS    = 200,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);
  localparam int DB_CYC   = DEBOUNCE_MS * CLK_FREQ_KHZ;
  localparam int LONG_CYC = LONG_MS * CLK_FREQ_KHZ;
  localparam int REP_CYC  = REPEAT_MS * CLK_FREQ_KHZ;

  // One fully independent channel per key.
  key_debounce_chan #(
    .DB_CYC(DB_CYC), .LONG_CYC(LONG_CYC), .REP_CYC(REP_CYC), .ACTIVE_LOW(ACTIVE_LOW)
  ) u_chan [NUM_KEYS-1:0] (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_pressed(key_pressed),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_repeat (key_repeat)
  );
endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed scenarios plus randomized rounds
// checked against a level/event-count model.
module tb_key_debounce_multi;
  localparam int NK = 4, DB = 20, LONG = 100, REP = 50, RLEN = 70;

  logic clk = 1'b0, rst = 1'b1;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_level, key_pressed, key_press, key_release, key_long, key_repeat;
  int n_chk = 0, n_err = 0;

  key_debounce_multi #(
    .NUM_KEYS(NK), .CLK_FREQ_KHZ(10), .DEBOUNCE_MS(2), .LONG_MS(10),
    .REPEAT_MS(5), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level),
    .key_pressed(key_pressed), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // event monitor, sampled 1 time unit after each rising edge
  int cyc = 0, n_strobe = 0;
  int n_press[NK], n_rel[NK], n_long[NK], n_rep[NK];
  int t_lvl[NK], t_press[NK], t_rel[NK], t_long[NK];
  int rep_t[$];
  logic [NK-1:0] lvl_prev = '1;
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < NK; i++) begin
      if (key_level[i] != lvl_prev[i]) t_lvl[i] = cyc;
      if (key_press[i])   begin n_press[i]++; t_press[i] = cyc; n_strobe++; end
      if (key_release[i]) begin n_rel[i]++;   t_rel[i]   = cyc; n_strobe++; end
      if (key_long[i])    begin n_long[i]++;  t_long[i]  = cyc; n_strobe++; end
      if (key_repeat[i])  begin n_rep[i]++;   n_strobe++; if (i == 2) rep_t.push_back(cyc); end
    end
    lvl_prev = key_level;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c0, base, np, nl, nr, nrel, rel_all;
    int bp[NK], br[NK], bl[NK], exp_p[NK], exp_r[NK], act[NK], off[NK], gl[NK];
    logic [NK-1:0] m_lvl;

    // reset
    repeat (5) @(negedge clk);
    chk("rst_level", key_level, 4'hF);
    chk("rst_pressed", key_pressed, 4'h0);
    chk("rst_strobes", {key_press, key_release, key_long, key_repeat}, 16'h0);
    base = n_strobe;
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("post_rst_strobes", n_strobe - base, 0);
    chk("post_rst_level", key_level, 4'hF);

    // bounce on key 0: every pulse is 7 cycles, far below DB
    base = n_strobe;
    for (int k = 0; k < 20; k++) begin
      key_in[0] = ~key_in[0];
      repeat (7) @(negedge clk);
    end
    key_in[0] = 1'b1;
    repeat (50) @(negedge clk);
    chk("bounce_level", key_level[0], 1'b1);
    chk("bounce_strobes", n_strobe - base, 0);

    // clean press/release on key 1
    np = n_press[1]; nrel = n_rel[1];
    key_in[1] = 1'b0; c0 = cyc;
    for (int k = 0; k < 100 && key_level[1] !== 1'b0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    $display("info: press level latency %0d", t_lvl[1] - c0);
    chk("press_level", key_level[1], 1'b0);
    chk("press_lat_win", (t_lvl[1] - c0) inside {[DB+2:DB+4]}, 1'b1);
    chk("press_next_cycle", t_press[1] - t_lvl[1], 1);
    repeat (30) @(negedge clk);
    chk("press_once", n_press[1] - np, 1);
    key_in[1] = 1'b1; c0 = cyc;
    for (int k = 0; k < 100 && key_level[1] !== 1'b1; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    $display("info: release level latency %0d", t_lvl[1] - c0);
    chk("release_lat_win", (t_lvl[1] - c0) inside {[DB+2:DB+4]}, 1'b1);
    chk("release_next_cycle", t_rel[1] - t_lvl[1], 1);
    repeat (30) @(negedge clk);
    chk("release_once", n_rel[1] - nrel, 1);
    chk("short_hold_no_long", n_long[1], 0);

    // long press / repeat on key 2
    np = n_press[2]; nl = n_long[2]; nr = n_rep[2]; nrel = n_rel[2];
    rep_t.delete();
    key_in[2] = 1'b0;
    repeat (400) @(negedge clk);
    key_in[2] = 1'b1;
    repeat (60) @(negedge clk);
    chk("long_press_cnt", n_press[2] - np, 1);
    chk("long_cnt", n_long[2] - nl, 1);
    $display("info: long delay %0d", t_long[2] - t_press[2]);
    chk("long_delay_win", (t_long[2] - t_press[2]) inside {[LONG-2:LONG+2]}, 1'b1);
    chk("long_release_cnt", n_rel[2] - nrel, 1);
`ifdef KEY_DEBOUNCE_REPEAT_EN
    chk("repeat_cnt", rep_t.size(), 5);
    for (int k = 0; k < rep_t.size(); k++)
      chk($sformatf("repeat_gap%0d", k),
          rep_t[k] - ((k == 0) ? t_long[2] : rep_t[k-1]), REP);
`else
    chk("repeat_cnt", n_rep[2] - nr, 0);
    chk("repeat_all_zero", n_rep[0] + n_rep[1] + n_rep[3], 0);
`endif

    // simultaneous press on keys 0 and 3, then reset while held
    key_in = 4'b0110;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (key_press != '0) break;
    end
    chk("simul_press", key_press, 4'b1001);
    repeat (30) @(negedge clk);
    chk("simul_pressed", key_pressed, 4'b1001);
    rel_all = n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3];
    rst = 1'b1; key_in = '1;
    repeat (3) @(negedge clk);
    chk("midrst_level", key_level, 4'hF);
    chk("midrst_pressed", key_pressed, 4'h0);
    chk("midrst_strobes", {key_press, key_release, key_long, key_repeat}, 16'h0);
    rst = 1'b0; base = n_strobe;
    repeat (60) @(negedge clk);
    chk("midrst_no_strobe", n_strobe - base, 0);
    chk("midrst_no_release", n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3] - rel_all, 0);

    // randomized rounds: per key hold / toggle / sub-DB glitch
    m_lvl = '1;
    for (int i = 0; i < NK; i++) begin
      bp[i] = n_press[i]; br[i] = n_rel[i]; bl[i] = n_long[i];
      exp_p[i] = 0; exp_r[i] = 0;
    end
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < NK; i++) begin
        if (!m_lvl[i])     act[i] = 1;   // a pressed key is always released next round
        else if (r == 23)  act[i] = 0;
        else               act[i] = $urandom_range(0, 2);
        off[i] = $urandom_range(0, 20);
        gl[i]  = $urandom_range(1, DB - 3);
        if (act[i] == 1) begin
          m_lvl[i] = ~m_lvl[i];
          if (!m_lvl[i]) exp_p[i]++; else exp_r[i]++;
        end
      end
      for (int c = 0; c < RLEN; c++) begin
        for (int i = 0; i < NK; i++)
          key_in[i] = (act[i] == 2 && c >= off[i] && c < off[i] + gl[i]) ? ~m_lvl[i] : m_lvl[i];
        @(negedge clk);
      end
      chk($sformatf("rand_level_r%0d", r), key_level, m_lvl);
    end
    for (int i = 0; i < NK; i++) begin
      chk($sformatf("rand_press_k%0d", i), n_press[i] - bp[i], exp_p[i]);
      chk($sformatf("rand_release_k%0d", i), n_rel[i] - br[i], exp_r[i]);
      chk($sformatf("rand_long_k%0d", i), n_long[i] - bl[i], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
